fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction fetch stage with a DEPTH-entry prefetch queue. It fetches sequentially from a stalling instruction memory or cache over a request/done handshake, with one request outstanding at a time. It buffers fetched instructions with their PC and PC+INC, and presents them to decode with a valid/dequeue handshake. Redirects flush the queue and discard any in-flight response; halt stops new fetches while the queue drains. It sits between the PC/branch-resolution logic and decode, and replaces the single-cycle, non-stalling fetch.

## Interface
- WIDTH, 16, PC and instruction width in bits
- DEPTH, 4, queue entries (power of two, ≥2)
- INC, 2, PC increment per instruction
- RESET_PC, 0, PC loaded at reset
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- redirect  in  1  load redirect_pc and flush (branch/jump taken)
- redirect_pc  in  WIDTH  target PC
- halt  in  1  stop issuing fetches (sticky)
- mem_req  out  1  fetch request, held until mem_done
- mem_addr  out  WIDTH  fetch address, stable while mem_req=1
- mem_done  in  1  response valid this cycle (only meaningful while mem_req=1)
- mem_rdata  in  WIDTH  instruction data, valid with mem_done
- mem_err  in  1  error qualifier, valid with mem_done
- instr_valid  out  1  queue head valid
- instr  out  WIDTH  head instruction
- instr_pc  out  WIDTH  PC of head
- instr_pcinc  out  WIDTH  instr_pc + INC (mod 2^WIDTH)
- deq  in  1  decode consumes head; ignored when instr_valid=0
- nop  out  1  registered; high for one cycle after a redirect flush
- err  out  1  sticky: a non-discarded response arrived with mem_err=1

## Operation
- Registered state: fetch_pc, queue storage, rd/wr pointers, count (0..DEPTH), FSM state, halted, err, nop.
- FSM states:
  - IDLE: mem_req=0.
  - WAIT: mem_req=1, mem_addr=fetch_pc.
  - DROP: mem_req=1; the pending response will be discarded.
- Transitions, evaluated in priority order:
  - redirect in WAIT without mem_done → DROP.
  - redirect in all other cases → IDLE. Also: fetch_pc←redirect_pc, count←0, halted←0, nop←1, and any same-cycle mem_done data is discarded.
  - DROP with mem_done → IDLE; data discarded; err unaffected.
  - WAIT with mem_done → enqueue {mem_rdata, fetch_pc}; fetch_pc←fetch_pc+INC; err|=mem_err. Stay in WAIT if halted=0, halt=0 and the post-update count < DEPTH; otherwise go to IDLE.
  - IDLE with halted=0, halt=0 and count < DEPTH → WAIT.
- halt sets halted. Halted blocks new issues only: an outstanding WAIT completes and enqueues normally, and the queue keeps draining.
- Queue: a same-cycle enqueue and deq is legal at any count, including full and empty-plus-enqueue; count is unchanged.
  - On an empty queue, the new entry is not visible until the next cycle (no bypass).
  - Pointers wrap modulo DEPTH.
- Full-queue invariant: the FSM is never in WAIT unless a free entry is reserved, so an enqueue is never dropped.
- PC arithmetic wraps modulo 2^WIDTH; carry is ignored.

## Timing
- Reset (rst_n=0, asynchronous) gives:
  - state=IDLE, fetch_pc=RESET_PC, count=0, halted=0
  - mem_req=0, instr_valid=0, nop=0, err=0
  - mem_addr=RESET_PC, instr/instr_pc/instr_pcinc=0
- First edge after rst_n deasserts: IDLE→WAIT; mem_req=1 with mem_addr=RESET_PC in the following cycle.
- With zero-wait memory (mem_done tied high), throughput is 1 instruction/cycle while space remains. Latency from mem_done to instr_valid is 1 cycle.
- With N-cycle memory, mem_addr is held for the full N cycles.
- nop is high for exactly the cycle after the redirect edge. instr_valid=0 in that same cycle.
- Reset mid-WAIT aborts the request immediately (mem_req=0). The memory must tolerate an abandoned request.

## Test plan
- Reset, then zero-wait memory with mem_rdata=addr^16'hA5A5 and deq=1 always → mem_addr 0,2,4,6…; instr_pc 0,2,4 on consecutive cycles from cycle 2; instr_pcinc=instr_pc+2.
- Stalling memory with mem_done every 3rd cycle and deq=0 → exactly 4 entries (pc 0,2,4,6), then mem_req=0 and count holds at 4. A single deq pulse → one new request at addr 8.
- Redirect to 16'h0100 during a 3-cycle WAIT at addr 4 → state DROP, and the response is discarded. Next request is addr 0x0100, the queue is empty, nop=1 for one cycle, and the first valid instr_pc is 0x0100.
- Redirect coincident with mem_done → data discarded, no enqueue, IDLE, then a request to redirect_pc.
- halt pulse while WAIT at addr 6 → addr 6 completes and is enqueued, no further mem_req, and the queue drains to instr_valid=0. A later redirect resumes fetching.
- mem_err=1 with mem_done on a kept response → err=1 and stays 1 until rst_n=0. mem_err during DROP → err stays 0.

Source files
------------

// File: rtl/fetch_queue.sv
// Sequential instruction fetch with a DEPTH-entry prefetch queue.
// One memory request outstanding; redirects flush the queue and drop in-flight data.
module fetch_queue #(
    parameter int               WIDTH    = 16,
    parameter int               DEPTH    = 4,
    parameter int               INC      = 2,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    input  logic             halt,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_done,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_err,
    output logic             instr_valid,
    output logic [WIDTH-1:0] instr,
    output logic [WIDTH-1:0] instr_pc,
    output logic [WIDTH-1:0] instr_pcinc,
    input  logic             deq,
    output logic             nop,
    output logic             err,
    output logic [1:0]       dbg_state
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);
    localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t state, state_d;

    logic [WIDTH-1:0] fetch_pc;
    logic [WIDTH-1:0] drop_addr;
    logic             halted;
    logic [PW-1:0]    rd_ptr, wr_ptr;
    logic [CW-1:0]    count, count_after;

    logic [WIDTH-1:0] q_instr [DEPTH];
    logic [WIDTH-1:0] q_pc    [DEPTH];
    logic [WIDTH-1:0] q_pcinc [DEPTH];

    logic enq, deq_eff, can_issue;

    // Handshakes: a memory transfer completes on a cycle with mem_req=1 and
    // mem_done=1; decode consumes the head on a cycle with instr_valid=1 and deq=1.
    assign instr_valid = (count != '0);
    assign deq_eff     = deq && instr_valid;
    assign enq         = (state == S_WAIT) && mem_done && !redirect;
    assign can_issue   = !halted && !halt;
    assign count_after = count + CW'(enq) - CW'(deq_eff);

    assign instr       = q_instr[rd_ptr];
    assign instr_pc    = q_pc[rd_ptr];
    assign instr_pcinc = q_pcinc[rd_ptr];
    assign dbg_state   = state;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // FSM next state; WAIT is only entered with a free slot, so enqueues never overflow
    always_comb begin
        state_d = state;
        if (redirect) begin
            state_d = (state == S_WAIT && !mem_done) ? S_DROP : S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (can_issue && count < DEPTH_C) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_done) begin
                        state_d = (can_issue && count_after < DEPTH_C) ? S_WAIT : S_IDLE;
                    end
                end
                S_DROP: begin
                    if (mem_done) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // FSM outputs; DROP keeps presenting the abandoned address until it completes
    always_comb begin
        mem_req  = (state == S_WAIT) || (state == S_DROP);
        mem_addr = (state == S_DROP) ? drop_addr : fetch_pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc  <= RESET_PC;
            drop_addr <= RESET_PC;
            halted    <= 1'b0;
            err       <= 1'b0;
            nop       <= 1'b0;
            count     <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
        end else begin
            nop <= redirect;
            if (redirect) begin
                fetch_pc <= redirect_pc;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                halted   <= 1'b0;
                if (state == S_WAIT) begin
                    drop_addr <= fetch_pc;
                end
            end else begin
                if (halt) begin
                    halted <= 1'b1;
                end
                if (enq) begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    fetch_pc <= fetch_pc + INC_W;
                    err      <= err | mem_err;
                end
                if (deq_eff) begin
                    rd_ptr <= rd_ptr + PW'(1);
                end
                count <= count_after;
            end
        end
    end

    // Queue storage is cleared at reset so the head reads as zero before any fetch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                q_instr[i] <= '0;
                q_pc[i]    <= '0;
                q_pcinc[i] <= '0;
            end
        end else if (enq) begin
            q_instr[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]    <= fetch_pc;
            q_pcinc[wr_ptr] <= fetch_pc + INC_W;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a simple latency-programmable memory
// responder plus hand-computed expectations for each scenario.
module tb_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_done;
    logic [15:0] mem_rdata;
    logic        mem_err;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic [15:0] instr_pcinc;
    logic        deq;
    logic        nop;
    logic        err;
    logic [1:0]  dbg_state;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    int n_checks = 0;
    int n_errors = 0;
    int mem_lat  = 1;
    int wait_cnt = 0;
    logic err_inject = 1'b0;
    logic [15:0] exp_q[$];
    logic [15:0] exp_pc;

    fetch_queue #(.WIDTH(16), .DEPTH(4), .INC(2), .RESET_PC(16'h0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_done    (mem_done),
        .mem_rdata   (mem_rdata),
        .mem_err     (mem_err),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_pcinc (instr_pcinc),
        .deq         (deq),
        .nop         (nop),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Memory responder: answers the current request after mem_lat cycles, then one clock.
    task automatic step();
        if (mem_req) begin
            wait_cnt++;
            if (wait_cnt >= mem_lat) begin
                mem_done  = 1'b1;
                mem_rdata = mem_addr ^ 16'hA5A5;
                wait_cnt  = 0;
            end else begin
                mem_done = 1'b0;
            end
        end else begin
            mem_done = 1'b0;
            wait_cnt = 0;
        end
        mem_err = mem_done & err_inject;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        steps(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        mem_done = 1'b0; mem_rdata = '0; mem_err = 1'b0; deq = 1'b0;

        // reset state
        do_reset();
        check_eq("rst_mem_req", 32'(mem_req), 32'h0);
        check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_valid", 32'(instr_valid), 32'h0);
        check_eq("rst_nop", 32'(nop), 32'h0);
        check_eq("rst_err", 32'(err), 32'h0);
        check_eq("rst_instr", 32'(instr), 32'h0);
        check_eq("rst_pc", 32'(instr_pc), 32'h0);
        check_eq("rst_pcinc", 32'(instr_pcinc), 32'h0);
        check_eq("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // zero-wait memory, decode always consuming
        mem_lat = 1; deq = 1'b1;
        step();
        check_eq("zw_req", 32'(mem_req), 32'h1);
        check_eq("zw_addr0", 32'(mem_addr), 32'h0);
        step();
        for (int i = 0; i < 6; i++) exp_q.push_back(16'(2 * i));
        while (exp_q.size() != 0) begin
            exp_pc = exp_q.pop_front();
            check_eq("zw_valid", 32'(instr_valid), 32'h1);
            check_eq("zw_pc", 32'(instr_pc), 32'(exp_pc));
            check_eq("zw_pcinc", 32'(instr_pcinc), 32'(exp_pc + 16'd2));
            check_eq("zw_instr", 32'(instr), 32'(exp_pc ^ 16'hA5A5));
            check_eq("zw_addr", 32'(mem_addr), 32'(exp_pc + 16'd2));
            step();
        end

        // reset during an outstanding request drops mem_req at once
        rst_n = 1'b0;
        #1;
        check_eq("rst_abort_req", 32'(mem_req), 32'h0);

        // 3-cycle memory, no consumption: fill to exactly 4 entries
        mem_lat = 3; deq = 1'b0;
        steps(2);
        rst_n = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 3; j++) begin
                check_eq("st_addr", 32'(mem_addr), 32'(2 * k));
                step();
            end
        end
        check_eq("full_req", 32'(mem_req), 32'h0);
        check_eq("full_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("full_head", 32'(instr_pc), 32'h0);
        steps(3);
        check_eq("full_hold_req", 32'(mem_req), 32'h0);
        deq = 1'b1;
        step();
        deq = 1'b0;
        check_eq("deq1_head", 32'(instr_pc), 32'h2);
        check_eq("deq1_noreq", 32'(mem_req), 32'h0);
        step();
        check_eq("refill_req", 32'(mem_req), 32'h1);
        check_eq("refill_addr", 32'(mem_addr), 32'h8);

        // redirect during a 3-cycle wait at addr 4, with an erroring dropped response
        do_reset();
        step();
        steps(6);
        check_eq("rd_addr4", 32'(mem_addr), 32'h4);
        step();
        redirect = 1'b1; redirect_pc = 16'h0100;
        step();
        redirect = 1'b0;
        check_eq("rd_state_drop", 32'(dbg_state), 32'(ST_DROP));
        check_eq("rd_drop_req", 32'(mem_req), 32'h1);
        check_eq("rd_drop_addr", 32'(mem_addr), 32'h4);
        check_eq("rd_nop", 32'(nop), 32'h1);
        check_eq("rd_nop_valid", 32'(instr_valid), 32'h0);
        err_inject = 1'b1;
        step();
        err_inject = 1'b0;
        check_eq("rd_idle", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("rd_nop_clr", 32'(nop), 32'h0);
        check_eq("rd_discard", 32'(instr_valid), 32'h0);
        check_eq("rd_drop_err", 32'(err), 32'h0);
        step();
        check_eq("rd_new_addr", 32'(mem_addr), 32'h0100);
        check_eq("rd_new_req", 32'(mem_req), 32'h1);
        steps(3);
        check_eq("rd_first_valid", 32'(instr_valid), 32'h1);
        check_eq("rd_first_pc", 32'(instr_pc), 32'h0100);
        check_eq("rd_first_instr", 32'(instr), 32'hA4A5);

        // redirect coincident with mem_done at addr 0x102
        steps(2);
        redirect = 1'b1; redirect_pc = 16'h0200; err_inject = 1'b1;
        step();
        redirect = 1'b0; err_inject = 1'b0;
        check_eq("co_state", 32'(dbg_state), 32'(ST_IDLE));
        check_eq("co_noreq", 32'(mem_req), 32'h0);
        check_eq("co_flush", 32'(instr_valid), 32'h0);
        check_eq("co_err", 32'(err), 32'h0);
        step();
        check_eq("co_addr", 32'(mem_addr), 32'h0200);

        // halt while waiting at addr 6
        do_reset();
        deq = 1'b1;
        step();
        steps(9);
        check_eq("h_addr6", 32'(mem_addr), 32'h6);
        halt = 1'b1;
        step();
        halt = 1'b0;
        steps(2);
        check_eq("h_enq6_valid", 32'(instr_valid), 32'h1);
        check_eq("h_enq6_pc", 32'(instr_pc), 32'h6);
        check_eq("h_noreq", 32'(mem_req), 32'h0);
        step();
        check_eq("h_drained", 32'(instr_valid), 32'h0);
        steps(3);
        check_eq("h_still_noreq", 32'(mem_req), 32'h0);
        redirect = 1'b1; redirect_pc = 16'h0040;
        step();
        redirect = 1'b0;
        step();
        check_eq("h_resume_addr", 32'(mem_addr), 32'h0040);
        check_eq("h_resume_req", 32'(mem_req), 32'h1);

        // error on a kept response is sticky until reset
        deq = 1'b0; err_inject = 1'b1;
        steps(3);
        err_inject = 1'b0;
        check_eq("e_set", 32'(err), 32'h1);

        // PC wrap at the top of the address space
        mem_lat = 1;
        redirect = 1'b1; redirect_pc = 16'hFFFE;
        step();
        redirect = 1'b0;
        step();
        check_eq("w_addr", 32'(mem_addr), 32'hFFFE);
        step();
        check_eq("w_pc", 32'(instr_pc), 32'hFFFE);
        check_eq("w_pcinc", 32'(instr_pcinc), 32'h0000);
        check_eq("w_next_addr", 32'(mem_addr), 32'h0000);
        check_eq("e_sticky", 32'(err), 32'h1);
        do_reset();
        check_eq("e_cleared", 32'(err), 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
